conv14x14_map_writer: RTL
=========================

# conv14x14_map_writer

Scan sequencer and result collector for the 14x14 convolution stage. It drives the 5x5 window-gather/dot-product datapath with a raster pixel index (0..195) and captures each returned 8-bit product into a packed 14x14 output feature map, so the full map can feed the next layer. It sits between the layer controller (start/done handshake) and the convolution datapath.

## Interface
- `IntSize`, 8: bits per pixel result.
- `PixCount`, 196: pixels per map (14x14).
- `Lat`, 0: register stages between `dp_state` and valid `dp_out`; legal values are 0..3.
- `clk` input 1: clock, with all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: begins one map scan. It is sampled only in IDLE.
- `dp_state` output 21: raster pixel index driven to the datapath (row = index/14, col = index%14).
- `dp_out` input IntSize: dot-product result for the index issued `Lat` cycles earlier.
- `fmap` output PixCount*IntSize: output map, with pixel k at `fmap[k*IntSize +: IntSize]`.
- `busy` output 1: high from the first issue cycle through the last capture cycle.
- `done` output 1: one-cycle pulse after the last pixel has been captured.

## Operation
- **States.** The block has three states: IDLE, ISSUE and DRAIN.
- **IDLE.** `busy`=0.
  - `start`=1 at an edge moves to ISSUE with `dp_state`=0.
- **ISSUE.** `dp_state` increments by 1 each edge until it reaches 195.
  - At 195: if `Lat`=0, go to IDLE and pulse `done`; otherwise go to DRAIN.
- **DRAIN.** Counts `Lat` cycles with `dp_state` held at 195, then goes to IDLE and pulses `done`.
- **Capture pipeline.** A `Lat`-deep pipeline carries a valid bit and the issued index.
  - At each edge where stage `Lat` is valid, `dp_out` is written to `fmap` slot [index].
  - For `Lat`=0, `dp_out` is captured at the edge that ends the cycle in which `dp_state`=index.
- **Outputs outside a scan.** `dp_state` holds its last value in IDLE (195 after a scan).
- **`fmap` retention.** `fmap` is not cleared by `start`. Every slot is overwritten during a scan, and old contents stay visible until their slot is rewritten.
- **Ignored `start`.** `start` is ignored while `busy`=1, and ignored in the cycle `done` is high.
  - A new scan can begin no earlier than the edge after the `done` pulse.
- **Index width.** `dp_state` is 21 bits wide. Upper bits are always 0, and the index never exceeds `PixCount-1`.
- **Reset.** `rst_n`=0 at an edge, including mid-scan, gives:
  - state IDLE
  - `dp_state`=0, `busy`=0, `done`=0
  - all `fmap` bits = 0
  - pipeline valid bits cleared
  - No partial-scan `done` is ever produced.

## Timing
- **Reset values.** `dp_state`=0, `fmap`=0, `busy`=0, `done`=0.
- **Scan start.** `start` is sampled high at edge E0.
  - `dp_state`=k for the cycle after edge E0+k, for k = 0..195.
  - `busy` rises after E0.
- **Capture.** Pixel k is captured at edge E0+k+1+`Lat`.
- **Scan end.** `busy` falls and `done` rises after edge E0+196+`Lat`. `done` is high for exactly one cycle.
- **Scan length.** Total `busy` cycles = 196+`Lat`.
  - Back-to-back scans: the period from one `start` edge to the next is 197+`Lat` cycles minimum.
- **Combinational paths.** There is no combinational path from `dp_out` or `start` to any output.

## Configuration
- **`CONV_RELU_EN` defined.** `dp_out` is treated as signed two's complement. Any captured value with bit `IntSize-1` set is written as 0; non-negative values are written unchanged.
- **`CONV_RELU_EN` undefined.** `dp_out` is written raw, with no modification.
- **Unaffected by the macro.** Timing, latency and the handshake are identical in both builds.

## Test plan
- **Basic scan.** `Lat`=0, datapath model returns `dp_out` = index[7:0] ^ 8'h5A, pulse `start`.
  - `dp_state` walks 0..195 on consecutive cycles.
  - `done` occurs 196 cycles after the start edge.
  - `fmap` slot k = k ^ 8'h5A for all k.
  - `busy` is high for exactly 196 cycles.
- **Pipelined datapath.** `Lat`=2, model delays its result by 2 registers.
  - `busy` is high for 198 cycles.
  - Slot 0 = 8'h5A, slot 195 = 8'h99.
  - No slot is written with a stale or shifted value.
- **Mid-scan reset.** Drop `rst_n` for 1 cycle when `dp_state`=100.
  - Next cycle: `fmap`=0, `busy`=0, `dp_state`=0.
  - No `done` pulse.
  - A new `start` completes a full, correct scan.
- **Ignored start.** Hold `start`=1 continuously through a scan.
  - Exactly one `done` per 197+`Lat` cycles.
  - A `start` asserted during `busy` never restarts the count mid-scan.
- **`CONV_RELU_EN` build.** Model returns 8'h80 for even k and 8'h7F for odd k.
  - Even slots = 8'h00, odd slots = 8'h7F.
  - Without the macro, even slots = 8'h80.
- **Rescan without clear.** Scan with all results = 8'hFF, then rescan with all results = 8'h01.
  - Slots still awaiting capture in the second scan read 8'hFF.
  - After the second `done`, every slot reads 8'h01.

Source files
------------

// File: rtl/conv14x14_map_writer.sv
// conv14x14_map_writer: raster scan sequencer and result collector for the
// 14x14 convolution stage. Issues pixel indices 0..PixCount-1 to the 5x5
// window datapath and writes each returned product into a packed output map.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst_n     - synchronous active-low reset
//   start     - begin one map scan (sampled only in IDLE, ignored while done)
//   dp_state  - raster pixel index driven to the datapath (upper bits zero)
//   dp_out    - datapath result for the index issued Lat cycles earlier
//   fmap      - output map, pixel k at fmap[k*IntSize +: IntSize]
//   busy      - high from the first issue cycle through the last capture cycle
//   done      - one-cycle pulse after the last pixel has been captured
//
// Build option: define CONV_RELU_EN to clamp negative (signed) results to 0
// before they are written; otherwise results are written raw.

module conv14x14_map_writer #(
   parameter int unsigned IntSize  = 8,
   parameter int unsigned PixCount = 196,
   parameter int unsigned Lat      = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic [20:0]                 dp_state,
   input  logic [IntSize-1:0]          dp_out,
   output logic [PixCount*IntSize-1:0] fmap,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned IdxW = $clog2(PixCount);
   localparam int unsigned CntW = 2;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(PixCount - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                           state;
   state_t                           state_nx;
   logic [IdxW-1:0]                  idx;
   logic [IdxW-1:0]                  idx_nx;
   logic [CntW-1:0]                  drain;
   logic [CntW-1:0]                  drain_nx;
   logic                             busy_nx;
   logic                             done_nx;
   logic                             issue_vld;
   logic                             cap_vld;
   logic [IdxW-1:0]                  cap_idx;
   logic [IntSize-1:0]               wdata;
   logic [PixCount-1:0][IntSize-1:0] map_q;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         drain <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         drain <= drain_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   // Next state: start is refused while the done pulse is still visible,
   // so back-to-back scans are spaced by at least one idle cycle.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      drain_nx = drain;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               state_nx = ISSUE;
               idx_nx   = '0;
            end
         end
         ISSUE: begin
            if (idx == LastIdx) begin
               if (Lat == 0) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = DRAIN;
                  drain_nx = CntW'(Lat - 1);
               end
            end else begin
               idx_nx = idx + IdxW'(1);
            end
         end
         DRAIN: begin
            if (drain == '0) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               drain_nx = drain - CntW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   assign dp_state  = 21'(idx);
   assign issue_vld = (state == ISSUE);

   // Capture pipeline: valid bit and index travel alongside the datapath
   // so the write slot always matches the result arriving on dp_out.
   if (Lat == 0) begin : g_nopipe
      assign cap_vld = issue_vld;
      assign cap_idx = idx;
   end else begin : g_pipe
      logic [Lat-1:0]      vld_sr;
      logic [Lat*IdxW-1:0] idx_sr;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_sr <= '0;
            idx_sr <= '0;
         end else begin
            vld_sr <= Lat'({vld_sr, issue_vld});
            idx_sr <= (Lat*IdxW)'({idx_sr, idx});
         end
      end

      assign cap_vld = vld_sr[Lat-1];
      assign cap_idx = idx_sr[Lat*IdxW-1 -: IdxW];
   end

   // Write-data shaping
   always_comb begin
      wdata = dp_out;
`ifdef CONV_RELU_EN
      if (dp_out[IntSize-1]) begin
         wdata = '0;
      end
`endif
   end

   // Output map; only reset clears it, a new scan overwrites slot by slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         map_q <= '0;
      end else if (cap_vld) begin
         map_q[cap_idx] <= wdata;
      end
   end

   assign fmap = map_q;

endmodule
